// File: rtl/ca_code_gen.sv
// ca_code_gen: GPS C/A Gold code generator (G1 ^ keyed G2) driven by half-chip strobes,
// producing early/prompt/late replicas, chip/epoch strobes and an epoch-aligned code slew.
module ca_code_gen #(
  parameter int CODE_LEN = 1023,
  parameter int SLEW_W   = 11
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              hc_enable,
  input  logic              prn_key_enable,
  input  logic [9:0]        prn_key,
  input  logic              slew_enable,
  input  logic [SLEW_W-1:0] slew,
  output logic              early,
  output logic              prompt,
  output logic              late,
  output logic              fc_enable,
  output logic              dump_enable,
  output logic [9:0]        code_phase,
  output logic              slew_busy
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACT} slew_st_t;

  slew_st_t          r_st, w_st_nxt;
  logic [9:0]        r_g1, r_g2, r_g2_key, r_cnt;
  logic [2:0]        r_srq;
  logic              r_phase, r_fc, r_dump;
  logic [SLEW_W-1:0] r_slew_cnt;
  logic              w_ca, w_hc_eff, w_fc, w_wrap, w_g1_fb, w_g2_fb, w_slew_ld, w_swallow;

  // bit i holds stage i+1, so stage10 is bit 9
  assign w_ca      = r_g1[9] ^ r_g2[9];
  assign w_g1_fb   = r_g1[2] ^ r_g1[9];
  assign w_g2_fb   = r_g2[1] ^ r_g2[2] ^ r_g2[5] ^ r_g2[7] ^ r_g2[8] ^ r_g2[9];
  assign w_hc_eff  = hc_enable & (r_st != S_ACT);
  assign w_fc      = w_hc_eff & r_phase;
  assign w_wrap    = w_fc & (r_cnt == 10'(CODE_LEN - 1));
  assign w_slew_ld = slew_enable & (slew != '0) & (r_st != S_ACT);
  assign w_swallow = hc_enable & (r_st == S_ACT);

  assign early       = r_srq[0];
  assign prompt      = r_srq[1];
  assign late        = r_srq[2];
  assign fc_enable   = r_fc;
  assign dump_enable = r_dump;
  assign code_phase  = r_cnt;
  assign slew_busy   = (r_st != S_IDLE);

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      S_IDLE:  w_st_nxt = w_slew_ld ? S_PEND : S_IDLE;
      S_PEND:  w_st_nxt = w_wrap ? S_ACT : S_PEND;
      S_ACT:   w_st_nxt = (w_swallow && r_slew_cnt == SLEW_W'(1)) ? S_IDLE : S_ACT;
      default: w_st_nxt = S_IDLE;
    endcase
    if (prn_key_enable) w_st_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_st <= S_IDLE;
    else       r_st <= w_st_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_g1       <= '1;
      r_g2       <= '1;
      r_g2_key   <= '1;
      r_cnt      <= '0;
      r_phase    <= 1'b0;
      r_srq      <= '0;
      r_fc       <= 1'b0;
      r_dump     <= 1'b0;
      r_slew_cnt <= '0;
    end else if (prn_key_enable) begin
      r_g1       <= '1;
      r_g2       <= prn_key;
      r_g2_key   <= prn_key;
      r_cnt      <= '0;
      r_phase    <= 1'b0;
      r_srq      <= '0;
      r_fc       <= 1'b0;
      r_dump     <= 1'b0;
      r_slew_cnt <= '0;
    end else begin
      r_fc   <= w_fc;
      r_dump <= w_wrap;
      if (w_hc_eff) begin
        r_srq   <= {r_srq[1:0], w_ca};
        r_phase <= ~r_phase;
      end
      if (w_fc) begin
        r_cnt <= w_wrap ? '0 : r_cnt + 10'd1;
        r_g1  <= w_wrap ? '1 : {r_g1[8:0], w_g1_fb};
        r_g2  <= w_wrap ? r_g2_key : {r_g2[8:0], w_g2_fb};
      end
      if (w_slew_ld) r_slew_cnt <= slew;
      else if (w_swallow) r_slew_cnt <= r_slew_cnt - SLEW_W'(1);
    end
  end

endmodule

// File: tb/tb_ca_code_gen.sv
// tb_ca_code_gen: scoreboard bench for ca_code_gen against an epoch-level golden C/A model.
`timescale 1ns/1ps
module tb_ca_code_gen;

  logic        clk = 0, rstn = 0;
  logic        hc_enable = 0, prn_key_enable = 0, slew_enable = 0;
  logic [9:0]  prn_key = '0;
  logic [10:0] slew = '0;
  logic        early, prompt, late, fc_enable, dump_enable, slew_busy;
  logic [9:0]  code_phase;

  ca_code_gen #(.CODE_LEN(1023), .SLEW_W(11)) dut (
    .clk(clk), .rstn(rstn), .hc_enable(hc_enable), .prn_key_enable(prn_key_enable),
    .prn_key(prn_key), .slew_enable(slew_enable), .slew(slew), .early(early),
    .prompt(prompt), .late(late), .fc_enable(fc_enable), .dump_enable(dump_enable),
    .code_phase(code_phase), .slew_busy(slew_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       fc, dump;
    logic [9:0] ph;
    logic       e, p, l, busy;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0;
  int   n_hc = 0, n_dump = 0, n_fc = 0, last_len = 0;

  logic       m_code [0:1022];
  int         m_h;
  logic [2:0] m_srq;
  logic       m_pend, m_act;
  int         m_slew;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic gen(input logic [9:0] key);
    logic [1:10] g1, g2;
    logic f1, f2;
    g1 = '1;
    for (int i = 1; i <= 10; i++) g2[i] = key[i-1];
    for (int c = 0; c < 1023; c++) begin
      m_code[c] = g1[10] ^ g2[10];
      f1 = g1[3] ^ g1[10];
      f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
      g1 = {f1, g1[1:9]};
      g2 = {f2, g2[1:9]};
    end
  endtask

  task automatic model_clear(input logic [9:0] key);
    gen(key);
    m_h = 0; m_srq = '0; m_pend = 0; m_act = 0; m_slew = 0;
  endtask

  function automatic exp_t snap(input logic fc, input logic dump);
    exp_t e;
    e.fc = fc; e.dump = dump; e.ph = 10'(m_h / 2);
    e.e = m_srq[0]; e.p = m_srq[1]; e.l = m_srq[2]; e.busy = m_pend | m_act;
    return e;
  endfunction

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    chk("fc", fc_enable, e.fc);
    chk("dump", dump_enable, e.dump);
    chk("code_phase", code_phase, e.ph);
    chk("early", early, e.e);
    chk("prompt", prompt, e.p);
    chk("late", late, e.l);
    chk("slew_busy", slew_busy, e.busy);
    if (fc_enable) n_fc++;
    if (dump_enable) begin n_dump++; last_len = n_hc; n_hc = 0; end
    @(posedge clk); #1;
    chk("fc_1clk", fc_enable, 0);
    chk("dump_1clk", dump_enable, 0);
  endtask

  task automatic hc_strobe();
    logic fc, dump;
    @(posedge clk); #1 hc_enable = 1;
    n_hc++;
    fc = 0; dump = 0;
    if (m_act) begin
      m_slew--;
      if (m_slew == 0) m_act = 0;
    end else begin
      m_srq = {m_srq[1:0], m_code[m_h / 2]};
      fc = m_h[0];
      dump = (m_h == 2045);
      m_h = (m_h + 1) % 2046;
      if (dump && m_pend) begin m_act = 1; m_pend = 0; end
    end
    sb.push_back(snap(fc, dump));
    @(posedge clk); #1 hc_enable = 0;
    check_out();
  endtask

  task automatic load_key(input logic [9:0] k, input logic with_hc, input logic with_slew);
    @(posedge clk); #1;
    prn_key_enable = 1; prn_key = k; hc_enable = with_hc; slew_enable = with_slew; slew = 11'd9;
    model_clear(k);
    sb.push_back(snap(0, 0));
    @(posedge clk); #1 prn_key_enable = 0; hc_enable = 0; slew_enable = 0;
    check_out();
  endtask

  task automatic slew_cmd(input int v);
    @(posedge clk); #1 slew_enable = 1; slew = 11'(v);
    if (!m_act && v != 0) begin m_pend = 1; m_slew = v; end
    sb.push_back(snap(0, 0));
    @(posedge clk); #1 slew_enable = 0;
    check_out();
  endtask

  task automatic run_dumps(input int n, input int max);
    int start = n_dump;
    int i = 0;
    while (n_dump - start < n && i < max) begin hc_strobe(); i++; end
    chk("run_dumps", n_dump - start, n);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_early"}, early, 0);
    chk({tag, "_prompt"}, prompt, 0);
    chk({tag, "_late"}, late, 0);
    chk({tag, "_fc"}, fc_enable, 0);
    chk({tag, "_dump"}, dump_enable, 0);
    chk({tag, "_phase"}, code_phase, 0);
    chk({tag, "_busy"}, slew_busy, 0);
  endtask

  initial begin
    model_clear(10'h3FF);
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rstn = 1;
    hc_strobe();
    chk("first_ca", early, 0);
    for (int i = 1; i < 2046; i++) hc_strobe();
    chk("fc_count", n_fc, 1023);
    chk("dump_count", n_dump, 1);

    for (int i = 0; i < 500; i++) hc_strobe();
    load_key(10'h3A5, 0, 0);
    n_hc = 0;
    for (int i = 0; i < 2046; i++) hc_strobe();
    chk("key_epoch_len", last_len, 2046);

    for (int i = 0; i < 700; i++) hc_strobe();
    slew_cmd(5);
    chk("slew_busy_set", slew_busy, 1);
    run_dumps(2, 6000);
    chk("slew5_len", last_len, 2051);

    load_key(10'h155, 1, 1);
    chk("simul_busy", slew_busy, 0);
    hc_strobe();
    hc_strobe();

    slew_cmd(3);
    run_dumps(1, 3000);
    chk("active_busy", slew_busy, 1);
    #3 rstn = 0;
    #1 check_zero("async_rst");
    model_clear(10'h3FF);
    #7 rstn = 1;
    n_hc = 0;
    run_dumps(1, 2100);
    chk("rst_epoch_len", last_len, 2046);

    slew_cmd(0);
    chk("slew0_busy", slew_busy, 0);
    for (int i = 0; i < 10; i++) hc_strobe();
    slew_cmd(4);
    for (int i = 0; i < 10; i++) hc_strobe();
    slew_cmd(7);
    run_dumps(2, 6000);
    chk("slew7_len", last_len, 2053);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
